// File: rtl/bus_pkg.sv
// Shared bus definitions: response codes, read-mux FSM states and a one-hot helper.
package bus_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } rdm_state_t;

    // Selects up to 64 slaves wide; callers zero-extend narrower vectors.
    function automatic logic onehot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/rdata_mux_wdog.sv
// Data-phase stall watchdog: counts consecutive stalled cycles and flags expiry
// on the cycle that would make the count reach TMO.
module rdata_mux_wdog #(
    parameter int TMO = 256
) (
    input  logic CLK,
    input  logic nRST,
    input  logic stall,
    output logic expire
);

    generate
        if (TMO > 0) begin : g_wdog
            localparam int CW = $clog2(TMO + 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = '0;
                if (stall) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire = stall && (cnt_q == CW'(TMO - 1));
        end else begin : g_off
            logic unused_wdog;
            assign unused_wdog = ^{CLK, nRST, stall};
            assign expire      = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/rdata_mux.sv
// Read-data return mux: routes the data-phase slave back to the masters and
// hosts the default slave (ERROR for unmapped transfers, abort of hung slaves).
module rdata_mux
    import bus_pkg::*;
#(
    parameter int NS  = 8,
    parameter int DW  = 32,
    parameter int TMO = 256
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [NS-1:0]   AsDEC,
    input  logic            AmVALID,
    input  logic [NS*DW-1:0] SxRDT,
    input  logic [NS-1:0]   SxRDY,
    input  logic [2*NS-1:0] SxRESP,
    output logic [DW-1:0]   MmRDT,
    output logic            MsRDY,
    output logic [1:0]      MsRESP,
    output logic [NS-1:0]   SsABORT,
    output logic [NS-1:0]   DsSEL
);

    rdm_state_t    state_q, state_d;
    logic [NS-1:0] ds_sel_q, ds_sel_d;
    logic          ds_vld_q, ds_vld_d;
    logic [NS-1:0] abort_q, abort_d;

    logic [DW-1:0] rdt_m  [NS];
    logic [1:0]    resp_m [NS];
    logic [DW-1:0] sel_rdt;
    logic [1:0]    sel_resp;
    logic          sel_rdy;
    logic          sel_oh;
    logic          as_oh;
    logic          stall;
    logic          expire;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_mask
            assign rdt_m[gi]  = ds_sel_q[gi] ? SxRDT[gi*DW +: DW]  : '0;
            assign resp_m[gi] = ds_sel_q[gi] ? SxRESP[2*gi +: 2]   : 2'b00;
        end
    endgenerate

    always_comb begin
        sel_rdt  = '0;
        sel_resp = 2'b00;
        for (int i = 0; i < NS; i++) begin
            sel_rdt  = sel_rdt | rdt_m[i];
            sel_resp = sel_resp | resp_m[i];
        end
    end

    assign sel_rdy = |(SxRDY & ds_sel_q);
    assign sel_oh  = onehot(64'(ds_sel_q));
    assign as_oh   = onehot(64'(AsDEC));
    assign stall   = (state_q == IDLE) && ds_vld_q && sel_oh && !sel_rdy;

    rdata_mux_wdog #(
        .TMO (TMO)
    ) u_wdog (
        .CLK    (CLK),
        .nRST   (nRST),
        .stall  (stall),
        .expire (expire)
    );

    // Master-side outputs; slaves are only observed in IDLE with a one-hot select.
    always_comb begin
        MmRDT  = '0;
        MsRDY  = 1'b1;
        MsRESP = RESP_OKAY;
        unique case (state_q)
            ERR1: begin
                MsRDY  = 1'b0;
                MsRESP = RESP_ERROR;
            end
            ERR2: begin
                MsRESP = RESP_ERROR;
            end
            default: begin
                if (sel_oh) begin
                    MmRDT  = sel_rdt;
                    MsRDY  = sel_rdy;
                    MsRESP = sel_resp;
                end else if (ds_vld_q) begin
                    MsRESP = RESP_ERROR;
                end
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ds_sel_d = ds_sel_q;
        ds_vld_d = ds_vld_q;
        abort_d  = '0;
        if (MsRDY) begin
            ds_sel_d = AsDEC;
            ds_vld_d = AmVALID;
        end
        unique case (state_q)
            ERR1: state_d = ERR2;
            ERR2: state_d = (AmVALID && !as_oh) ? ERR1 : IDLE;
            default: begin
                if (MsRDY && AmVALID && !as_oh) begin
                    state_d = ERR1;
                end else if (expire) begin
                    state_d = ERR1;
                    abort_d = ds_sel_q;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ds_sel_q <= '0;
            ds_vld_q <= 1'b0;
            abort_q  <= '0;
        end else begin
            state_q  <= state_d;
            ds_sel_q <= ds_sel_d;
            ds_vld_q <= ds_vld_d;
            abort_q  <= abort_d;
        end
    end

    // abort_q is only ever loaded on the way into ERR1, so it is visible for that one cycle.
    assign SsABORT = (state_q == ERR1) ? abort_q : '0;
    assign DsSEL   = ds_sel_q;

endmodule

// File: tb/tb_rdata_mux.sv
// Directed plus random bench for rdata_mux against a transaction-level model.
module tb_rdata_mux;

    localparam int NS  = 8;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [NS-1:0]   as_dec;
    logic            am_valid;
    logic [NS*DW-1:0] sx_rdt;
    logic [NS-1:0]   sx_rdy;
    logic [2*NS-1:0] sx_resp;
    logic [DW-1:0]   MmRDT;
    logic            MsRDY;
    logic [1:0]      MsRESP;
    logic [NS-1:0]   SsABORT;
    logic [NS-1:0]   DsSEL;

    int checks = 0;
    int errors = 0;

    // Model state: current data phase, remaining error cycles, stall run length.
    logic [NS-1:0] m_sel;
    logic          m_vld;
    int            m_err;
    int            m_stall;
    logic [NS-1:0] m_abort;

    logic [DW-1:0] e_rdt;
    logic          e_rdy;
    logic [1:0]    e_resp;
    logic [NS-1:0] e_abort;

    rdata_mux #(.NS(NS), .DW(DW), .TMO(TMO)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .AsDEC   (as_dec),
        .AmVALID (am_valid),
        .SxRDT   (sx_rdt),
        .SxRDY   (sx_rdy),
        .SxRESP  (sx_resp),
        .MmRDT   (MmRDT),
        .MsRDY   (MsRDY),
        .MsRESP  (MsRESP),
        .SsABORT (SsABORT),
        .DsSEL   (DsSEL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int first_bit(input logic [NS-1:0] v);
        for (int k = 0; k < NS; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_sel = '0; m_vld = 1'b0; m_err = 0; m_stall = 0; m_abort = '0;
    endtask

    task automatic model_expect();
        int k;
        e_rdt = '0; e_rdy = 1'b1; e_resp = 2'b00; e_abort = '0;
        if (m_err == 2) begin
            e_rdy = 1'b0; e_resp = 2'b01; e_abort = m_abort;
        end else if (m_err == 1) begin
            e_resp = 2'b01;
        end else if ($countones(m_sel) == 1) begin
            k = first_bit(m_sel);
            e_rdt  = sx_rdt[k*DW +: DW];
            e_rdy  = sx_rdy[k];
            e_resp = sx_resp[2*k +: 2];
        end else if (m_vld) begin
            e_resp = 2'b01;
        end
    endtask

    task automatic model_clock();
        if (m_err == 2) begin
            m_err = 1; m_stall = 0; m_abort = '0;
        end else if (e_rdy) begin
            m_sel = as_dec; m_vld = am_valid; m_stall = 0; m_abort = '0;
            m_err = (am_valid && $countones(as_dec) != 1) ? 2 : 0;
        end else if (m_vld) begin
            m_stall++;
            if (m_stall == TMO) begin
                m_err = 2; m_abort = m_sel; m_stall = 0;
            end
        end else begin
            m_stall = 0;
        end
    endtask

    // One bus cycle: compare on the falling edge, advance the model on the rising edge.
    task automatic cycle(input string tag);
        @(negedge CLK);
        model_expect();
        chk({tag, ".rdt"},   32'(MmRDT),   32'(e_rdt));
        chk({tag, ".rdy"},   32'(MsRDY),   32'(e_rdy));
        chk({tag, ".resp"},  32'(MsRESP),  32'(e_resp));
        chk({tag, ".abort"}, 32'(SsABORT), 32'(e_abort));
        chk({tag, ".dssel"}, 32'(DsSEL),   32'(m_sel));
        $display("cycle %s: AsDEC=%h V=%b RDT=%h RDY=%b RESP=%0d ABORT=%h DsSEL=%h",
                 tag, as_dec, am_valid, MmRDT, MsRDY, MsRESP, SsABORT, DsSEL);
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic slaves_idle();
        for (int k = 0; k < NS; k++) sx_rdt[k*DW +: DW] = $urandom;
        sx_rdy  = '1;
        sx_resp = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rdy"},   32'(MsRDY),   32'd1);
        chk({tag, ".resp"},  32'(MsRESP),  32'd0);
        chk({tag, ".rdt"},   32'(MmRDT),   32'd0);
        chk({tag, ".abort"}, 32'(SsABORT), 32'd0);
        chk({tag, ".dssel"}, 32'(DsSEL),   32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #1 nRST = 1'b0;
        #1 chk_reset_vals(tag);
        $display("async reset %s: RDY=%b RESP=%0d DsSEL=%h", tag, MsRDY, MsRESP, DsSEL);
        #1 nRST = 1'b1;
        model_reset();
    endtask

    initial begin
        nRST = 1'b0; as_dec = '0; am_valid = 1'b0;
        sx_rdt = '0; sx_rdy = '1; sx_resp = '0;
        model_reset();

        // 1: reset state
        #3 chk_reset_vals("t1_reset");
        #9 nRST = 1'b1;
        @(posedge CLK); #1;
        cycle("t1_idle");

        // 2: slave2 stalls two cycles then returns data
        as_dec = 8'h04; am_valid = 1'b1; slaves_idle();
        cycle("t2_addr");
        as_dec = '0; am_valid = 1'b0;
        sx_rdt[2*DW +: DW] = 32'hDEADBEEF; sx_rdy[2] = 1'b0;
        repeat (2) begin
            #1 chk("t2_stall_rdy", 32'(MsRDY), 32'd0);
            chk("t2_stall_sel", 32'(DsSEL), 32'h04);
            cycle("t2_stall");
        end
        sx_rdy[2] = 1'b1;
        #1 chk("t2_data", MmRDT, 32'hDEADBEEF);
        chk("t2_rdy", 32'(MsRDY), 32'd1);
        cycle("t2_data");

        // 3: unmapped transfers chain ERR1,ERR2,ERR1,ERR2
        as_dec = 8'h00; am_valid = 1'b1;
        cycle("t3_addr0");
        #1 chk("t3_err1a", {30'd0, MsRDY, MsRESP[0]}, 32'b01);
        as_dec = 8'h05;
        cycle("t3_err1a");
        #1 chk("t3_err2a", {30'd0, MsRDY, MsRESP[0]}, 32'b11);
        cycle("t3_err2a");
        as_dec = '0; am_valid = 1'b0;
        #1 chk("t3_err1b", 32'(MsRESP), 32'd1);
        cycle("t3_err1b");
        cycle("t3_err2b");
        cycle("t3_idle");

        // 4: watchdog aborts hung slave3, then slave1 completes
        as_dec = 8'h08; am_valid = 1'b1; slaves_idle();
        cycle("t4_addr");
        as_dec = '0; am_valid = 1'b0; sx_rdy[3] = 1'b0;
        repeat (4) cycle("t4_stall");
        #1 chk("t4_abort", 32'(SsABORT), 32'h08);
        cycle("t4_err1");
        chk("t4_abort_gone", 32'(SsABORT), 32'h00);
        as_dec = 8'h02; am_valid = 1'b1;
        cycle("t4_err2");
        as_dec = '0; am_valid = 1'b0;
        sx_rdt[1*DW +: DW] = 32'h12345678; sx_rdy[1] = 1'b1;
        #1 chk("t4_s1_data", MmRDT, 32'h12345678);
        cycle("t4_s1");

        // 5: async reset in ERR1 and mid-stall, then slave0 transfer
        as_dec = 8'h00; am_valid = 1'b1;
        cycle("t5_addr_err");
        pulse_reset("t5_rst_err1");
        as_dec = 8'h01; am_valid = 1'b1; slaves_idle();
        cycle("t5_addr_s0");
        as_dec = '0; am_valid = 1'b0; sx_rdy[0] = 1'b0;
        cycle("t5_stall");
        pulse_reset("t5_rst_stall");
        sx_rdy[0] = 1'b1;
        as_dec = 8'h01; am_valid = 1'b1;
        cycle("t5_addr_s0b");
        as_dec = '0; am_valid = 1'b0; sx_rdt[0 +: DW] = 32'hA5A5_5A5A;
        #1 chk("t5_s0_data", MmRDT, 32'hA5A5_5A5A);
        cycle("t5_s0");

        // 6: RETRY passes through, FSM stays IDLE
        as_dec = 8'h20; am_valid = 1'b1; slaves_idle();
        cycle("t6_addr");
        as_dec = '0; am_valid = 1'b0; sx_resp[10 +: 2] = 2'b10;
        #1 chk("t6_retry", 32'(MsRESP), 32'd2);
        cycle("t6_retry");
        sx_resp = '0;
        #1 chk("t6_after", {30'd0, MsRDY, MsRESP[0]}, 32'b10);
        cycle("t6_idle");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      as_dec = NS'(1) << $urandom_range(0, NS-1);
            else if (r < 8) as_dec = '0;
            else            as_dec = NS'($urandom);
            am_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NS; k++) begin
                sx_rdt[k*DW +: DW] = $urandom;
                sx_rdy[k]          = ($urandom_range(0, 3) != 0);
                sx_resp[2*k +: 2]  = 2'($urandom_range(0, 3));
            end
            // Slaves answer idle phases with OKAY and RDY=1.
            if (m_err == 0 && !m_vld && $countones(m_sel) == 1) begin
                sx_rdy[first_bit(m_sel)] = 1'b1;
                sx_resp[2*first_bit(m_sel) +: 2] = 2'b00;
            end
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
